// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: issues a one-cycle condition-evaluate command to the status
// register, samples the returned condition and emits a registered branch resolution.
// Optional BRANCH_SEQ_FAST_UNCOND_EN: mask 0 requests resolve at the acceptance edge.
module branch_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                branch_valid_in,
  output logic                branch_ready_out,
  input  logic [3:0]          branch_mask_in,
  input  logic                branch_invert_in,
  input  logic [PC_WIDTH-1:0] branch_target_in,
  input  logic                abort_in,
  output logic [3:0]          status_inst_out,
  output logic                status_copy_en_out,
  output logic                status_invert_out,
  input  logic                cond_in,
  output logic                pc_load_en_out,
  output logic [PC_WIDTH-1:0] pc_load_value_out,
  output logic                branch_done_out,
  output logic                branch_taken_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE} state_t;

  state_t              state_q;
  logic [3:0]          status_inst_q;
  logic                status_copy_en_q;
  logic                status_invert_q;
  logic [PC_WIDTH-1:0] target_q;
  logic                pc_load_en_q;
  logic [PC_WIDTH-1:0] pc_load_value_q;
  logic                branch_done_q;
  logic                branch_taken_q;
  logic                fast_uncond;

`ifdef BRANCH_SEQ_FAST_UNCOND_EN
  assign fast_uncond = (branch_mask_in == 4'b0000);
`else
  assign fast_uncond = 1'b0;
`endif

  // The status command registers double as the latched mask/invert: they only matter in ISSUE.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q          <= IDLE;
      status_inst_q    <= '0;
      status_copy_en_q <= 1'b0;
      status_invert_q  <= 1'b0;
      target_q         <= '0;
      pc_load_en_q     <= 1'b0;
      pc_load_value_q  <= '0;
      branch_done_q    <= 1'b0;
      branch_taken_q   <= 1'b0;
    end else begin
      branch_done_q    <= 1'b0;
      pc_load_en_q     <= 1'b0;
      status_copy_en_q <= 1'b0;
      status_inst_q    <= '0;
      status_invert_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (branch_valid_in) begin
            target_q <= branch_target_in;
            if (fast_uncond) begin
              branch_done_q   <= 1'b1;
              branch_taken_q  <= branch_invert_in;
              pc_load_en_q    <= branch_invert_in;
              pc_load_value_q <= branch_target_in;
            end else begin
              state_q          <= ISSUE;
              status_copy_en_q <= 1'b1;
              status_inst_q    <= branch_mask_in;
              status_invert_q  <= branch_invert_in;
            end
          end
        end
        ISSUE: state_q <= abort_in ? IDLE : SAMPLE;
        SAMPLE: begin
          state_q <= IDLE;
          if (!abort_in) begin
            branch_done_q   <= 1'b1;
            branch_taken_q  <= cond_in;
            pc_load_en_q    <= cond_in;
            pc_load_value_q <= target_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign branch_ready_out   = (state_q == IDLE);
  assign status_inst_out    = status_inst_q;
  assign status_copy_en_out = status_copy_en_q;
  assign status_invert_out  = status_invert_q;
  assign pc_load_en_out     = pc_load_en_q;
  assign pc_load_value_out  = pc_load_value_q;
  assign branch_done_out    = branch_done_q;
  assign branch_taken_out   = branch_taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed-vector bench for branch_sequencer: a table of per-edge stimulus/expectation
// records plus hand-written reset and mask-0 sequences.
module tb_branch_sequencer;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       branch_valid_in;
  logic       branch_ready_out;
  logic [3:0] branch_mask_in;
  logic       branch_invert_in;
  logic [7:0] branch_target_in;
  logic       abort_in;
  logic [3:0] status_inst_out;
  logic       status_copy_en_out;
  logic       status_invert_out;
  logic       cond_in;
  logic       pc_load_en_out;
  logic [7:0] pc_load_value_out;
  logic       branch_done_out;
  logic       branch_taken_out;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  branch_sequencer #(.PC_WIDTH(8)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .branch_valid_in(branch_valid_in), .branch_ready_out(branch_ready_out),
    .branch_mask_in(branch_mask_in), .branch_invert_in(branch_invert_in),
    .branch_target_in(branch_target_in), .abort_in(abort_in),
    .status_inst_out(status_inst_out), .status_copy_en_out(status_copy_en_out),
    .status_invert_out(status_invert_out), .cond_in(cond_in),
    .pc_load_en_out(pc_load_en_out), .pc_load_value_out(pc_load_value_out),
    .branch_done_out(branch_done_out), .branch_taken_out(branch_taken_out)
  );

  // Inputs applied before an edge; expected outputs as seen just after that edge.
  typedef struct {
    logic       valid;
    logic [3:0] mask;
    logic       inv;
    logic [7:0] tgt;
    logic       abort;
    logic       cond;
    logic       e_ready;
    logic       e_copy;
    logic [3:0] e_inst;
    logic       e_sinv;
    logic       e_done;
    logic       e_taken;
    logic       e_pcl;
    logic [7:0] e_pcv;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] m, input logic i,
                       input logic [7:0] t, input logic a, input logic c);
    branch_valid_in  = v;
    branch_mask_in   = m;
    branch_invert_in = i;
    branch_target_in = t;
    abort_in         = a;
    cond_in          = c;
  endtask

  task automatic check(input string name, input logic e_ready, input logic e_copy,
                       input logic [3:0] e_inst, input logic e_sinv, input logic e_done,
                       input logic e_taken, input logic e_pcl, input logic [7:0] e_pcv);
    logic [17:0] act;
    logic [17:0] exp;
    act = {branch_ready_out, status_copy_en_out, status_inst_out, status_invert_out,
           branch_done_out, branch_taken_out, pc_load_en_out, pc_load_value_out};
    exp = {e_ready, e_copy, e_inst, e_sinv, e_done, e_taken, e_pcl, e_pcv};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got {rdy,copy,inst,sinv,done,taken,pcl,pcv}=%05h want %05h", name, act, exp);
    end else begin
      $display("ok   %s: outputs=%05h", name, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            v  mask   i  tgt    ab c   rdy cp inst  si dn tk pl pcv
    vecs.push_back('{1, 4'h1, 0, 8'h3C, 0, 0,  0, 1, 4'h1, 0, 0, 0, 0, 8'h00}); // accept -> ISSUE
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  0, 0, 4'h0, 0, 0, 0, 0, 8'h00}); // SAMPLE
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 1,  1, 0, 4'h0, 0, 1, 1, 1, 8'h3C}); // taken
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  1, 0, 4'h0, 0, 0, 1, 0, 8'h3C}); // pulse ends, hold
    vecs.push_back('{1, 4'h1, 0, 8'h3C, 0, 0,  0, 1, 4'h1, 0, 0, 1, 0, 8'h3C});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 1,  0, 0, 4'h0, 0, 0, 1, 0, 8'h3C}); // cond in ISSUE ignored
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  1, 0, 4'h0, 0, 1, 0, 0, 8'h3C}); // not taken
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  1, 0, 4'h0, 0, 0, 0, 0, 8'h3C});
    vecs.push_back('{1, 4'hA, 1, 8'h55, 0, 0,  0, 1, 4'hA, 1, 0, 0, 0, 8'h3C});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 1, 1,  1, 0, 4'h0, 0, 0, 0, 0, 8'h3C}); // abort in ISSUE
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 1,  1, 0, 4'h0, 0, 0, 0, 0, 8'h3C}); // no late pulse
    vecs.push_back('{1, 4'h2, 0, 8'h77, 0, 0,  0, 1, 4'h2, 0, 0, 0, 0, 8'h3C});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 1,  0, 0, 4'h0, 0, 0, 0, 0, 8'h3C});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 1, 1,  1, 0, 4'h0, 0, 0, 0, 0, 8'h3C}); // abort in SAMPLE
    vecs.push_back('{1, 4'h4, 1, 8'h99, 1, 0,  0, 1, 4'h4, 1, 0, 0, 0, 8'h3C}); // abort ignored in IDLE
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  0, 0, 4'h0, 0, 0, 0, 0, 8'h3C});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 1,  1, 0, 4'h0, 0, 1, 1, 1, 8'h99});
    vecs.push_back('{1, 4'h8, 0, 8'h10, 0, 0,  0, 1, 4'h8, 0, 0, 1, 0, 8'h99}); // first of pair
    vecs.push_back('{1, 4'h8, 0, 8'h20, 0, 0,  0, 0, 4'h0, 0, 0, 1, 0, 8'h99}); // held while busy
    vecs.push_back('{1, 4'h8, 0, 8'h20, 0, 1,  1, 0, 4'h0, 0, 1, 1, 1, 8'h10}); // first resolves
    vecs.push_back('{1, 4'h8, 0, 8'h20, 0, 0,  0, 1, 4'h8, 0, 0, 1, 0, 8'h10}); // accepted in done cycle
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  0, 0, 4'h0, 0, 0, 1, 0, 8'h10});
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  1, 0, 4'h0, 0, 1, 0, 0, 8'h20}); // second, 3 edges later
    vecs.push_back('{0, 4'h0, 0, 8'h00, 0, 0,  1, 0, 4'h0, 0, 0, 0, 0, 8'h20});

    reset_n_in = 1'b0;
    drive(0, 4'h0, 0, 8'h00, 0, 0);
    #12;
    check("reset_state", 1, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    @(posedge clk_in);
    #1 reset_n_in = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].mask, vecs[k].inv, vecs[k].tgt, vecs[k].abort, vecs[k].cond);
      tick();
      check($sformatf("vec%0d", k), vecs[k].e_ready, vecs[k].e_copy, vecs[k].e_inst,
            vecs[k].e_sinv, vecs[k].e_done, vecs[k].e_taken, vecs[k].e_pcl, vecs[k].e_pcv);
    end

    // Mask 0, invert 1: condition evaluates to the invert bit.
    drive(1, 4'h0, 1, 8'h42, 0, 1);
    tick();
`ifdef BRANCH_SEQ_FAST_UNCOND_EN
    check("uncond_fast_done", 1, 0, 4'h0, 0, 1, 1, 1, 8'h42);
    drive(0, 4'h0, 0, 8'h00, 0, 0);
    tick();
    check("uncond_fast_after", 1, 0, 4'h0, 0, 0, 1, 0, 8'h42);
`else
    check("uncond_issue", 0, 1, 4'h0, 1, 0, 0, 0, 8'h20);
    drive(0, 4'h0, 0, 8'h00, 0, 1);
    tick();
    check("uncond_sample", 0, 0, 4'h0, 0, 0, 0, 0, 8'h20);
    tick();
    check("uncond_done", 1, 0, 4'h0, 0, 1, 1, 1, 8'h42);
    drive(0, 4'h0, 0, 8'h00, 0, 0);
    tick();
`endif

    // Reset asserted mid-SAMPLE takes effect without waiting for a clock edge.
    drive(1, 4'h3, 0, 8'hE7, 0, 1);
    tick();
    drive(0, 4'h0, 0, 8'h00, 0, 1);
    tick();
    check("reset_pre_sample", 0, 0, 4'h0, 0, 0, 1, 0, 8'h42);
    #2 reset_n_in = 1'b0;
    #1;
    check("reset_async", 1, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    tick();
    #1 reset_n_in = 1'b1;
    tick();
    check("reset_no_done", 1, 0, 4'h0, 0, 0, 0, 0, 8'h00);
    tick();
    check("reset_still_idle", 1, 0, 4'h0, 0, 0, 0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Initiator side of the status-flag condition interface.
- Accepts a conditional-branch request from the decoder and issues a one-cycle condition-evaluate command (mask, invert, copy enable) to the status register.
- Samples the registered condition bit it returns, then emits a registered branch resolution (taken flag, PC load strobe, target).
- Sits between the instruction decoder, the status register and the program counter of the tiny CPU.

Parameters:
- PC_WIDTH, 8, width of branch target and PC load value.

Ports:
- clk_in  input  1  system clock, all state on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- branch_valid_in  input  1  branch request valid.
- branch_ready_out  output  1  sequencer can accept a request.
- branch_mask_in  input  4  flag select mask for the request.
- branch_invert_in  input  1  invert the condition for the request.
- branch_target_in  input  PC_WIDTH  branch destination.
- abort_in  input  1  cancel an in-flight branch (pipeline flush).
- status_inst_out  output  4  mask to status register.
- status_copy_en_out  output  1  evaluate-condition strobe to status register.
- status_invert_out  output  1  invert control to status register.
- cond_in  input  1  registered condition bit from status register.
- pc_load_en_out  output  1  one-cycle PC load strobe (branch taken).
- pc_load_value_out  output  PC_WIDTH  target presented with pc_load_en_out.
- branch_done_out  output  1  one-cycle resolution pulse.
- branch_taken_out  output  1  resolution result, valid with branch_done_out.

Behaviour:
- Reset (reset_n_in low, async): state IDLE; every output 0 except branch_ready_out=1; latched mask/invert/target cleared.
- States: IDLE, ISSUE, SAMPLE.
- IDLE:
  - branch_ready_out=1.
  - On an edge with branch_valid_in=1: latch mask, invert and target, then go to ISSUE.
- ISSUE (one cycle):
  - status_copy_en_out=1; status_inst_out=latched mask; status_invert_out=latched invert. Next state SAMPLE.
  - Condition uses flags as registered before this cycle's edge; a same-cycle flag write is not seen.
- SAMPLE (one cycle):
  - cond_in is valid.
  - At the edge: branch_done_out<=1, branch_taken_out<=cond_in, pc_load_en_out<=cond_in, pc_load_value_out<=latched target. Next state IDLE.
- Result outputs:
  - branch_done_out and pc_load_en_out are high for exactly one cycle (the first IDLE cycle after SAMPLE), then return to 0.
  - branch_taken_out and pc_load_value_out hold until the next resolution.
- Outside ISSUE, status_copy_en_out, status_inst_out and status_invert_out are 0.
- Latency: acceptance edge E0 → ISSUE cycle → SAMPLE cycle → done visible in the cycle after edge E2 (3 edges).
- Back-to-back: a request may be accepted in the same IDLE cycle that branch_done_out is high.
- branch_ready_out=0 in ISSUE and SAMPLE. Requests presented then are not accepted; the requester holds them.
- abort_in:
  - Sampled in ISSUE or SAMPLE: next state IDLE, with no branch_done_out and no pc_load_en_out.
  - The ISSUE-cycle copy strobe still goes out; the status register update is harmless.
  - Ignored in IDLE. abort_in and branch_valid_in together in IDLE: the request is accepted.
- Reset mid-operation: returns to IDLE immediately; any pending resolution is dropped.

Optional Feature:
- Macro: BRANCH_SEQ_FAST_UNCOND_EN.
- Defined:
  - A request with branch_mask_in=4'b0000 bypasses ISSUE/SAMPLE. No status strobe is issued.
  - At the acceptance edge: branch_done_out<=1, branch_taken_out<=branch_invert_in, pc_load_en_out<=branch_invert_in.
  - State stays IDLE; latency is 1 edge.
- Undefined:
  - Mask 0 takes the normal 3-edge path; the status register returns 0, so taken = invert.
  - The result is identical; only latency differs.

Test Plan:
- Reset low mid-SAMPLE → all outputs 0, ready=1 immediately; no done pulse after release.
- Request mask=4'b0001, invert=0, target=8'h3C; drive cond_in=1 in SAMPLE → status_copy_en_out=1 with inst=4'b0001 exactly one cycle after acceptance; two cycles later done=1, taken=1, pc_load_en=1, pc_load_value=8'h3C.
- Same request, cond_in=0 → done=1, taken=0, pc_load_en=0; taken stays 0 afterwards.
- Two requests back-to-back (second valid held during busy; target 8'h10 then 8'h20) → second accepted in the done cycle of the first; two resolutions 3 cycles apart with correct targets.
- abort_in=1 during ISSUE → return to IDLE, no done/pc_load pulse; next request resolves normally.
- Mask=4'b0000, invert=1 → with BRANCH_SEQ_FAST_UNCOND_EN: done/taken/pc_load after 1 edge, no copy strobe; without it: copy strobe, then done/taken=1 after 3 edges.
